// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared encodings for the multi-cycle ALU: RV32I opcode,
//               funct3 and funct7 values plus the controller state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    // funct3 operation select (shared by OP and OP-IMM)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 variants
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_OUT  = 2'd3
    } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Iterative shift-add multiplier. A start pulse loads the
//               operands; WIDTH iterations later done pulses for one cycle
//               and product holds the low WIDTH bits of a*b.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  c_iters  = CW'(WIDTH);
    localparam logic [CW-1:0]  c_one    = CW'(1);
    localparam logic [CW-1:0]  c_zero   = CW'(0);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_run;

    // One multiplier bit per cycle: add the shifted multiplicand when the
    // current multiplier LSB is set; bits above WIDTH fall off naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= c_zero;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= c_iters;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == c_zero) begin
                r_run <= 1'b0;
            end else begin
                if (r_b[0]) begin
                    r_acc <= r_acc + r_a;
                end
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt - c_one;
            end
        end
    end

    assign o_done    = r_run && (r_cnt == c_zero);
    assign o_product = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle RV32I-style OP / OP-IMM integer ALU with a
//               valid/ready handshake. Single-cycle operations complete
//               through EXEC; MUL (only when ALU_MUL_EN is defined) iterates
//               in the alu_mul_seq sub-module. Illegal encodings return
//               out=0 with err=1.
//               Build option: define ALU_MUL_EN to include the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32   // >= 8, power of two
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    output logic             ready,
    output logic             busy,
    output logic             err,
    output logic [WIDTH-1:0] out
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       r_state;
    logic [6:0]       r_opcode;
    logic [2:0]       r_funct3;
    logic [6:0]       r_funct7;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_err;
    logic             r_ready;

    logic             w_sel_mul;
    logic [WIDTH-1:0] w_exec_res;
    logic             w_exec_err;

    // Shared funct3 datapath; alt selects SUB for ADD and SRA for SRL.
    function automatic logic [WIDTH-1:0] f_base_op(
        input logic [2:0]       f3,
        input logic             alt,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] sra;
        sh  = b[SHW-1:0];
        // Kept as a standalone statement so the shift stays signed.
        sra = $signed(a) >>> sh;
        case (f3)
            F3_ADD:  return alt ? (a - b) : (a + b);
            F3_SLL:  return a << sh;
            F3_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            F3_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
            F3_XOR:  return a ^ b;
            F3_SRL:  return alt ? sra : (a >> sh);
            F3_OR:   return a | b;
            F3_AND:  return a & b;
            default: return '0;
        endcase
    endfunction

`ifdef ALU_MUL_EN
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod;

    assign w_sel_mul   = (opcode == OPC_OP) && (funct7 == F7_MULDIV) && (funct3 == F3_ADD);
    // Multiplier loads straight from the ports on the accepting edge.
    assign w_mul_start = (r_state == ST_IDLE) && valid && w_sel_mul;

    alu_mul_seq #(
        .WIDTH     (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (in_A),
        .i_b       (in_B),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );
`else
    assign w_sel_mul = 1'b0;
`endif

    // Decode the latched request; MUL encodings never reach EXEC when the
    // multiplier is built, so here they are always illegal.
    always_comb begin
        w_exec_res = '0;
        w_exec_err = 1'b0;
        case (r_opcode)
            OPC_OP: begin
                if (r_funct7 == F7_BASE) begin
                    w_exec_res = f_base_op(r_funct3, 1'b0, r_a, r_b);
                end else if ((r_funct7 == F7_ALT) &&
                             ((r_funct3 == F3_ADD) || (r_funct3 == F3_SRL))) begin
                    w_exec_res = f_base_op(r_funct3, 1'b1, r_a, r_b);
                end else begin
                    w_exec_err = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if ((r_funct3 == F3_SLL) && (r_funct7 != F7_BASE)) begin
                    w_exec_err = 1'b1;
                end else if ((r_funct3 == F3_SRL) && (r_funct7 != F7_BASE) &&
                             (r_funct7 != F7_ALT)) begin
                    w_exec_err = 1'b1;
                end else begin
                    // Only the shift-right slot has an alternate form for
                    // immediates; elsewhere funct7 is immediate data.
                    w_exec_res = f_base_op(r_funct3,
                                           (r_funct3 == F3_SRL) && (r_funct7 == F7_ALT),
                                           r_a, r_b);
                end
            end
            default: begin
                w_exec_err = 1'b1;
            end
        endcase
    end

    // Controller: accept in IDLE, compute or iterate, pulse ready in OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
            r_funct3 <= '0;
            r_funct7 <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_out    <= '0;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid) begin
                        r_opcode <= opcode;
                        r_funct3 <= funct3;
                        r_funct7 <= funct7;
                        r_a      <= in_A;
                        r_b      <= in_B;
                        r_state  <= w_sel_mul ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_out   <= w_exec_res;
                    r_err   <= w_exec_err;
                    r_ready <= 1'b1;
                    r_state <= ST_OUT;
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_out   <= w_mul_prod;
                        r_err   <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_OUT;
                    end
                end
`endif
                ST_OUT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign busy  = (r_state != ST_IDLE);
    assign err   = r_err;
    assign out   = r_out;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mc
// Description : Scoreboard bench for alu_mc. Two instances (WIDTH=32 and
//               WIDTH=16) share one request stream; each has its own queue
//               of expected responses popped by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam bit MUL_EN =
`ifdef ALU_MUL_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          issue;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] a32, b32;
    logic [15:0] a16, b16;
    logic        ready32, busy32, err32;
    logic        ready16, busy16, err16;
    logic [31:0] out32;
    logic [15:0] out16;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q32[$];
    exp_t q16[$];
    logic [31:0] last32, last16;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .in_A(a32), .in_B(b32), .ready(ready32), .busy(busy32),
        .err(err32), .out(out32)
    );

    alu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .in_A(a16), .in_B(b16), .ready(ready16), .busy(busy16),
        .err(err16), .out(out16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endfunction

    // Reference model from the instruction-set rules, at width w.
    function automatic void model(input int w, input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] a_in, input logic [31:0] b_in,
                                  output logic [31:0] res, output logic err, output bit mul);
        longint unsigned mask, a, b, v;
        longint          sa, sb;
        int              sh, kind;
        mask = (64'd1 << w) - 64'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        sa   = ((a >> (w - 1)) & 1) != 0 ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb   = ((b >> (w - 1)) & 1) != 0 ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        sh   = int'(b % longint'(w));
        kind = -1;
        if (opc == 7'h33) begin
            if (f7 == 7'h00)                     kind = int'(f3);
            else if (f7 == 7'h20 && f3 == 3'd0)  kind = 8;
            else if (f7 == 7'h20 && f3 == 3'd5)  kind = 9;
            else if (f7 == 7'h01 && f3 == 3'd0 && MUL_EN) kind = 10;
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1)      kind = (f7 == 7'h00) ? 1 : -1;
            else if (f3 == 3'd5) kind = (f7 == 7'h00) ? 5 : (f7 == 7'h20) ? 9 : -1;
            else                 kind = int'(f3);
        end
        case (kind)
            0:  v = a + b;
            1:  v = a << sh;
            2:  v = (sa < sb) ? 1 : 0;
            3:  v = (a < b) ? 1 : 0;
            4:  v = a ^ b;
            5:  v = a >> sh;
            6:  v = a | b;
            7:  v = a & b;
            8:  v = a - b;
            9:  v = sa >>> sh;
            10: v = a * b;
            default: v = 0;
        endcase
        res = 32'(v & mask);
        err = (kind < 0);
        mul = (kind == 10);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Bounded wait until every issued request has been answered.
    task automatic wait_done();
        int n;
        n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < 200) begin
            step();
            n++;
        end
        if (q32.size() != 0 || q16.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: got %0d/%0d pending responses expected 0", q32.size(), q16.size());
            q32.delete();
            q16.delete();
        end else begin
            check("w32_out_held", out32, last32);
            check("w16_out_held", {16'h0, out16}, last16);
        end
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e32, input logic x32,
                         input logic [31:0] e16, input logic x16,
                         input bit mul, input bit hold);
        exp_t e;
        wait_done();
        step();
        opcode = opc; funct3 = f3; funct7 = f7;
        a32 = a; b32 = b; a16 = a[15:0]; b16 = b[15:0];
        valid = 1'b1;
        e.issue = cyc;
        e.res = e32; e.err = x32; e.lat = mul ? 34 : 2;
        q32.push_back(e);
        e.res = e16; e.err = x16; e.lat = mul ? 18 : 2;
        q16.push_back(e);
        last32 = e32;
        last16 = e16;
        step();
        check("w32_busy", {31'b0, busy32}, 32'd1);
        if (hold) wait_done();
        valid = 1'b0;
    endtask

    task automatic issue_m(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input bit hold);
        logic [31:0] r32, r16;
        logic        x32, x16;
        bit          m;
        model(32, opc, f3, f7, a, b, r32, x32, m);
        model(16, opc, f3, f7, a, b, r16, x16, m);
        issue(opc, f3, f7, a, b, r32, x32, r16, x16, m, hold);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitors: pop and compare whenever a DUT presents ready.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && ready32 === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w32_unexpected_ready: got ready=1 expected no response");
            end else begin
                e = q32.pop_front();
                check("w32_out", out32, e.res);
                check("w32_err", {31'b0, err32}, {31'b0, e.err});
                check("w32_latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && ready16 === 1'b1) begin
            if (q16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w16_unexpected_ready: got ready=1 expected no response");
            end else begin
                e = q16.pop_front();
                check("w16_out", {16'h0, out16}, e.res);
                check("w16_err", {31'b0, err16}, {31'b0, e.err});
                check("w16_latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    initial begin
        logic [6:0] opc, f7;
        logic [2:0] f3;
        int         r;
        rst = 1'b1; valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        a32 = '0; b32 = '0; a16 = '0; b16 = '0;
        last32 = '0; last16 = '0;
        step(); step();
        check("reset_out32", out32, 32'h0);
        check("reset_flags32", {29'b0, ready32, busy32, err32}, 32'h0);
        check("reset_out16", {16'h0, out16}, 32'h0);
        check("reset_flags16", {29'b0, ready16, busy16, err16}, 32'h0);
        rst = 1'b0;

        // Directed cases with hand-derived results at both widths
        issue(7'h33, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(7'h33, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'hFFFE, 1'b0, 1'b0, 1'b0);
        issue(7'h13, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(7'h13, 3'd5, 7'h20, 32'h8000_8000, 32'd4, 32'hF800_0800, 1'b0, 32'hF800, 1'b0, 1'b0, 1'b0);
        issue(7'h33, 3'd5, 7'h00, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(7'h33, 3'd5, 7'h00, 32'h8000_8000, 32'd4, 32'h0800_0800, 1'b0, 32'h0800, 1'b0, 1'b0, 1'b0);
        issue(7'h33, 3'd1, 7'h00, 32'h4000_0003, 32'h21, 32'h8000_0006, 1'b0, 32'h0006, 1'b0, 1'b0, 1'b0);
        issue(7'h33, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0);
        issue(7'h33, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        issue(7'h13, 3'd3, 7'h55, 32'd0, 32'd1, 32'd1, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0);
        issue(7'h33, 3'd0, 7'h01, 32'h0001_0003, 32'h0001_0005,
              MUL_EN ? 32'h0008_000F : 32'h0, !MUL_EN, MUL_EN ? 32'h000F : 32'h0, !MUL_EN, MUL_EN, 1'b0);
        issue(7'h7F, 3'd0, 7'h00, 32'h1234_5678, 32'h1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        issue(7'h33, 3'd1, 7'h20, 32'h1, 32'h1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        issue(7'h13, 3'd1, 7'h20, 32'h1, 32'h1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);

        // valid held through busy: exactly one response expected
        issue(7'h33, 3'd0, 7'h00, 32'h0000_1111, 32'h0000_2222, 32'h3333, 1'b0, 32'h3333, 1'b0, 1'b0, 1'b1);

        // Abort mid-EXEC; the aborted request must never answer
        issue(7'h33, 3'd6, 7'h00, 32'h00F0_00F0, 32'h0F00_0F00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("abort_out32", out32, 32'h0);
        check("abort_flags32", {29'b0, ready32, busy32, err32}, 32'h0);
        check("abort_out16", {16'h0, out16}, 32'h0);
        check("abort_flags16", {29'b0, ready16, busy16, err16}, 32'h0);
        q32.delete();
        q16.delete();
        last32 = '0;
        last16 = '0;
        step();
        rst = 1'b0;
        issue(7'h33, 3'd4, 7'h00, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 32'hA5A5, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            r   = $urandom_range(0, 9);
            opc = (r < 4) ? 7'h33 : (r < 8) ? 7'h13 : 7'($urandom);
            f3  = 3'($urandom);
            r   = $urandom_range(0, 9);
            f7  = (r < 5) ? 7'h00 : (r < 7) ? 7'h20 : (r < 9) ? 7'h01 : 7'($urandom);
            issue_m(opc, f3, f7, pick(), pick(), ($urandom_range(0, 7) == 0) && (f7 != 7'h01));
        end
        wait_done();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
